// File: rtl/buyruk_bellegi.sv
// Instruction memory for the single-cycle core: a byte-serial loader fills the word
// array, and then the core fetches from it combinationally once the loader is in HAZIR.
module buyruk_bellegi #(
  parameter int          DERINLIK = 256,
  parameter int          ADR_W    = 8,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             yukle_basla,
  input  logic             yukle_gecerli,
  input  logic [7:0]       yukle_bayt,
  input  logic             yukle_son,
  output logic             yukle_hazir,
  output logic             islemci_calistir,
  input  logic [31:0]      ps,
  output logic [31:0]      buyruk,
  output logic [ADR_W:0]   kelime_sayisi,
  output logic [1:0]       hata
);

  typedef enum logic [1:0] {BOSTA, YUKLE, HAZIR} durum_t;

  durum_t         durum_q, durum_d;
  logic [1:0]     idx_q, idx_d;
  logic [ADR_W:0] sayi_q, sayi_d;
  logic [23:0]    topla_q, topla_d;
  logic [1:0]     hata_q, hata_d;
  logic           hazir_q, calistir_q;

  logic [31:0]    mem [DERINLIK];
  logic           yaz;
  logic [31:0]    yaz_kelime;
  logic           dolu;
  logic           getir_ok;

  // The word count doubles as the write pointer; it never wraps past DERINLIK.
  assign dolu     = (sayi_q == (ADR_W+1)'(DERINLIK));
  assign getir_ok = (durum_q == HAZIR) && (ps[1:0] == 2'b00) &&
                    (ps[31:2] < 30'(sayi_q));

  assign buyruk           = getir_ok ? mem[ps[ADR_W+1:2]] : NOP;
  assign kelime_sayisi    = sayi_q;
  assign hata             = hata_q;
  assign yukle_hazir      = hazir_q;
  assign islemci_calistir = calistir_q;

  always_comb begin
    durum_d    = durum_q;
    idx_d      = idx_q;
    sayi_d     = sayi_q;
    topla_d    = topla_q;
    hata_d     = hata_q;
    yaz        = 1'b0;
    // Upper bytes above the current index are still zero, so a partial word is zero-padded.
    yaz_kelime = {8'h00, topla_q} | ({24'h000000, yukle_bayt} << {idx_q, 3'b000});
    unique case (durum_q)
      BOSTA: begin
        if (yukle_basla) begin
          durum_d = YUKLE;
          idx_d   = 2'd0;
          sayi_d  = '0;
          topla_d = '0;
          hata_d  = 2'b00;
        end
      end
      YUKLE: begin
        if (yukle_gecerli) begin
          if (dolu) begin
            hata_d[0] = 1'b1;
          end else if (idx_q == 2'd3 || yukle_son) begin
            yaz     = 1'b1;
            sayi_d  = sayi_q + (ADR_W+1)'(1);
            idx_d   = 2'd0;
            topla_d = '0;
          end else begin
            topla_d = yaz_kelime[23:0];
            idx_d   = idx_q + 2'd1;
          end
          if (yukle_son) durum_d = HAZIR;
        end
      end
      HAZIR: begin
        if (yukle_basla) begin
          durum_d = YUKLE;
          idx_d   = 2'd0;
          sayi_d  = '0;
          topla_d = '0;
          hata_d  = 2'b00;
        end else if (!getir_ok) begin
          hata_d[1] = 1'b1;
        end
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      durum_q    <= BOSTA;
      idx_q      <= 2'd0;
      sayi_q     <= '0;
      topla_q    <= '0;
      hata_q     <= 2'b00;
      hazir_q    <= 1'b0;
      calistir_q <= 1'b0;
    end else begin
      durum_q    <= durum_d;
      idx_q      <= idx_d;
      sayi_q     <= sayi_d;
      topla_q    <= topla_d;
      hata_q     <= hata_d;
      hazir_q    <= (durum_d == YUKLE);
      calistir_q <= (durum_d == HAZIR);
    end
  end

  // Memory is deliberately left out of reset; kelime_sayisi=0 hides stale contents.
  always_ff @(posedge clk) begin
    if (yaz) mem[sayi_q[ADR_W-1:0]] <= yaz_kelime;
  end

endmodule

// File: tb/tb_buyruk_bellegi.sv
// Randomized bench for buyruk_bellegi with a 4-word memory; expected words are rebuilt
// from the byte stream by plain little-endian packing.
module tb_buyruk_bellegi;

  localparam int          D    = 4;
  localparam int          AW   = 2;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        yukle_basla, yukle_gecerli, yukle_son;
  logic [7:0]  yukle_bayt;
  logic        yukle_hazir, islemci_calistir;
  logic [31:0] ps, buyruk;
  logic [AW:0] kelime_sayisi;
  logic [1:0]  hata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  prog_q[$];
  logic [31:0] exp_w[D];
  int          exp_cnt;
  logic        exp_ovf;

  buyruk_bellegi #(.DERINLIK(D), .ADR_W(AW), .NOP(NOPW)) dut (
    .clk(clk), .rst(rst),
    .yukle_basla(yukle_basla), .yukle_gecerli(yukle_gecerli),
    .yukle_bayt(yukle_bayt), .yukle_son(yukle_son),
    .yukle_hazir(yukle_hazir), .islemci_calistir(islemci_calistir),
    .ps(ps), .buyruk(buyruk), .kelime_sayisi(kelime_sayisi), .hata(hata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input int stall_at, input int stall_len);
    yukle_basla = 1'b1;
    tick();
    yukle_basla = 1'b0;
    for (int i = 0; i < prog_q.size(); i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          yukle_gecerli = 1'b0;
          yukle_bayt    = 8'hEE;
          tick();
          n_cmp++;
          if (yukle_hazir !== 1'b1) begin
            $display("FAIL hazir_stall: got %b want 1", yukle_hazir);
            n_bad++;
          end
        end
      end
      n_cmp++;
      if (yukle_hazir !== 1'b1) begin
        $display("FAIL hazir_byte%0d: got %b want 1", i, yukle_hazir);
        n_bad++;
      end
      yukle_gecerli = 1'b1;
      yukle_bayt    = prog_q[i];
      yukle_son     = (i == prog_q.size() - 1);
      tick();
    end
    yukle_gecerli = 1'b0;
    yukle_son     = 1'b0;
  endtask

  task automatic check_load(input string nm);
    int n, nw;
    n       = prog_q.size();
    nw      = (n + 3) / 4;
    exp_cnt = (nw > D) ? D : nw;
    exp_ovf = (n > 4 * D);
    for (int w = 0; w < D; w++) exp_w[w] = 32'h0;
    for (int i = 0; i < n && i < 4 * D; i++)
      exp_w[i / 4] = exp_w[i / 4] | (32'(prog_q[i]) << (8 * (i % 4)));

    n_cmp++;
    if (islemci_calistir !== 1'b1) begin
      $display("FAIL %s_calistir: got %b want 1", nm, islemci_calistir); n_bad++;
    end
    n_cmp++;
    if (yukle_hazir !== 1'b0) begin
      $display("FAIL %s_hazir: got %b want 0", nm, yukle_hazir); n_bad++;
    end
    n_cmp++;
    if (kelime_sayisi !== 3'(exp_cnt)) begin
      $display("FAIL %s_sayi: got %0d want %0d", nm, kelime_sayisi, exp_cnt); n_bad++;
    end
    n_cmp++;
    if (hata !== {1'b0, exp_ovf}) begin
      $display("FAIL %s_hata: got %b want %b", nm, hata, {1'b0, exp_ovf}); n_bad++;
    end
    // All probes stay within one clock phase so no edge samples an invalid ps.
    for (int w = 0; w < exp_cnt; w++) begin
      ps = 32'(4 * w);
      #0.5;
      n_cmp++;
      if (buyruk !== exp_w[w]) begin
        $display("FAIL %s_word%0d: got %h want %h", nm, w, buyruk, exp_w[w]); n_bad++;
      end
    end
    ps = 32'(4 * exp_cnt);
    #0.5;
    n_cmp++;
    if (buyruk !== NOPW) begin
      $display("FAIL %s_beyond: got %h want %h", nm, buyruk, NOPW); n_bad++;
    end
    ps = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    n_cmp++;
    if ({yukle_hazir, islemci_calistir, kelime_sayisi, hata} !== 7'b0) begin
      $display("FAIL reset_outs: got hz=%b cal=%b sayi=%0d hata=%b want all 0",
               yukle_hazir, islemci_calistir, kelime_sayisi, hata); n_bad++;
    end
    n_cmp++;
    if (buyruk !== NOPW) begin
      $display("FAIL reset_buyruk: got %h want %h", buyruk, NOPW); n_bad++;
    end
    #10 rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    prog_q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h00, 8'h00, 8'h00};
    load_prog(-1, 0);
    check_load("basic");
    ps = 32'h0; #0.5;
    n_cmp++;
    if (buyruk !== 32'h0010_0513) begin
      $display("FAIL basic_ps0: got %h want 00100513", buyruk); n_bad++;
    end
    ps = 32'h4; #0.5;
    n_cmp++;
    if (buyruk !== 32'h0000_00B3) begin
      $display("FAIL basic_ps4: got %h want 000000b3", buyruk); n_bad++;
    end
    ps = 32'h0;
    tick();
  endtask

  task automatic test_invalid();
    ps = 32'h8; #0.5;
    n_cmp++;
    if (buyruk !== NOPW) begin
      $display("FAIL inv_range: got %h want %h", buyruk, NOPW); n_bad++;
    end
    tick();
    n_cmp++;
    if (hata[1] !== 1'b1) begin
      $display("FAIL inv_hata1: got %b want 1", hata[1]); n_bad++;
    end
    ps = 32'h2; #0.5;
    n_cmp++;
    if (buyruk !== NOPW) begin
      $display("FAIL inv_misalign: got %h want %h", buyruk, NOPW); n_bad++;
    end
    tick();
    ps = 32'h0; #0.5;
    n_cmp++;
    if (hata !== 2'b10) begin
      $display("FAIL inv_sticky: got %b want 10", hata); n_bad++;
    end
  endtask

  task automatic test_reload();
    yukle_basla = 1'b1;
    tick();
    yukle_basla = 1'b0;
    n_cmp++;
    if ({islemci_calistir, yukle_hazir, kelime_sayisi, hata} !== {1'b0, 1'b1, 3'd0, 2'b00}) begin
      $display("FAIL reload_state: got cal=%b hz=%b sayi=%0d hata=%b want cal=0 hz=1 sayi=0 hata=00",
               islemci_calistir, yukle_hazir, kelime_sayisi, hata); n_bad++;
    end
    n_cmp++;
    if (buyruk !== NOPW) begin
      $display("FAIL reload_nop: got %h want %h", buyruk, NOPW); n_bad++;
    end
    prog_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_prog(-1, 0);
    check_load("reload");
    tick();
  endtask

  task automatic test_partial();
    prog_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
    load_prog(-1, 0);
    check_load("partial");
    ps = 32'h4; #0.5;
    n_cmp++;
    if (buyruk !== 32'h0000_00AA) begin
      $display("FAIL partial_ps4: got %h want 000000aa", buyruk); n_bad++;
    end
    ps = 32'h0;
    tick();
  endtask

  task automatic test_stall_overflow();
    prog_q = {};
    for (int i = 0; i < 20; i++) prog_q.push_back(8'($urandom));
    load_prog(2, 3);
    check_load("ovf");
    tick();
  endtask

  task automatic test_reset_midload();
    yukle_basla = 1'b1;
    tick();
    yukle_basla = 1'b0;
    for (int i = 0; i < 6; i++) begin
      yukle_gecerli = 1'b1;
      yukle_bayt    = 8'($urandom);
      tick();
    end
    #1 rst = 1'b0;
    #0.5;
    n_cmp++;
    if ({yukle_hazir, islemci_calistir, kelime_sayisi} !== 5'b0) begin
      $display("FAIL midrst_outs: got hz=%b cal=%b sayi=%0d want 0", yukle_hazir,
               islemci_calistir, kelime_sayisi); n_bad++;
    end
    for (int k = 0; k < 3; k++) begin
      ps = (k == 0) ? 32'h0 : {$urandom_range(0, 7), 2'b00};
      #0.5;
      n_cmp++;
      if (buyruk !== NOPW) begin
        $display("FAIL midrst_nop%0d: got %h want %h", k, buyruk, NOPW); n_bad++;
      end
    end
    yukle_gecerli = 1'b0;
    ps = 32'h0;
    #1 rst = 1'b1;
    tick();
    n_cmp++;
    if (yukle_hazir !== 1'b0 || islemci_calistir !== 1'b0) begin
      $display("FAIL midrst_idle: got hz=%b cal=%b want 0 0", yukle_hazir, islemci_calistir);
      n_bad++;
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int n;
      n = $urandom_range(1, 20);
      prog_q = {};
      for (int i = 0; i < n; i++) prog_q.push_back(8'($urandom));
      load_prog($urandom_range(0, n - 1), $urandom_range(0, 3));
      check_load($sformatf("rnd%0d", it));
      tick();
    end
  endtask

  initial begin
    yukle_basla   = 1'b0;
    yukle_gecerli = 1'b0;
    yukle_son     = 1'b0;
    yukle_bayt    = 8'h00;
    ps            = 32'h0;
    test_reset();
    test_basic();
    test_invalid();
    test_reload();
    test_partial();
    test_stall_overflow();
    test_reset_midload();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
